// File: rtl/register_bank_pkg.sv
// Shared sizes and types for the 32 x 64-bit integer register file.
package register_bank_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = {ADDR_W{1'b0}};

endpackage

// File: rtl/register_bank_read_port.sv
// Combinational read port: zero-register rule plus optional same-cycle write forwarding.
// Forwarding is compiled in when REGISTER_BANK_WRITE_BYPASS_EN is defined.
module register_bank_read_port
  import register_bank_pkg::*;
(
  input  logic [ADDR_W-1:0] index,
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_index,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data
);

`ifndef REGISTER_BANK_WRITE_BYPASS_EN
  logic unused_s;
  assign unused_s = ^{wr_en, wr_index, wr_data};
`endif

  // Select stored contents, forwarded write data, or zero for x0.
  always_comb begin
    data = {DATA_W{1'b0}};
    if (index == ZERO_REG) begin
      data = {DATA_W{1'b0}};
`ifdef REGISTER_BANK_WRITE_BYPASS_EN
    end else if (wr_en && (wr_index == index)) begin
      data = wr_data;
`endif
    end else begin
      data = regs[index];
    end
  end

endmodule

// File: rtl/register_bank.sv
// 32 x 64-bit register file, two combinational read ports, one synchronous write port.
// Optional write-to-read forwarding: define REGISTER_BANK_WRITE_BYPASS_EN.
module register_bank
  import register_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] register1,
  input  logic [ADDR_W-1:0] register2,
  input  logic [ADDR_W-1:0] register3,
  input  logic [DATA_W-1:0] datain,
  input  logic              regwrite,
  output logic [DATA_W-1:0] dataout1,
  output logic [DATA_W-1:0] dataout2
);

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic              wr_en_s;

  // Forwarding must not leak datain while the bank is held in reset.
  assign wr_en_s = regwrite & rst_n;

  // Storage: async clear of every entry, writes to x0 dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (regwrite && (register3 != ZERO_REG)) begin
      regs_r[register3] <= datain;
    end
  end

  register_bank_read_port u_read_port1 (
    .index    (register1),
    .regs     (regs_r),
    .wr_en    (wr_en_s),
    .wr_index (register3),
    .wr_data  (datain),
    .data     (dataout1)
  );

  register_bank_read_port u_read_port2 (
    .index    (register2),
    .regs     (regs_r),
    .wr_en    (wr_en_s),
    .wr_index (register3),
    .wr_data  (datain),
    .data     (dataout2)
  );

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank (both forwarding builds).
module tb_register_bank;

  logic        clk;
  logic        rst_n;
  logic [4:0]  register1;
  logic [4:0]  register2;
  logic [4:0]  register3;
  logic [63:0] datain;
  logic        regwrite;
  logic [63:0] dataout1;
  logic [63:0] dataout2;

  int checks;
  int errors;

  register_bank dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .register1 (register1),
    .register2 (register2),
    .register3 (register3),
    .datain    (datain),
    .regwrite  (regwrite),
    .dataout1  (dataout1),
    .dataout2  (dataout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [63:0] val);
    @(negedge clk);
    register3 = idx;
    datain    = val;
    regwrite  = 1'b1;
    @(posedge clk);
    #1;
    regwrite  = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    register1 = 5'd5;
    register2 = 5'd31;
    register3 = 5'd0;
    datain    = 64'h0;
    regwrite  = 1'b0;
    #12;
    check("reset_state_rd1", dataout1, 64'h0);
    check("reset_state_rd2", dataout2, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write/read
    write_reg(5'd2, 64'h123456789ABCDEF0);
    register1 = 5'd2;
    register2 = 5'd1;
    #1;
    check("basic_rd1", dataout1, 64'h123456789ABCDEF0);
    check("basic_unwritten_rd2", dataout2, 64'h0);

    // regwrite gating
    @(negedge clk);
    register3 = 5'd3;
    datain    = 64'hDEADBEEF00000000;
    regwrite  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    register1 = 5'd3;
    #1;
    check("gated_write", dataout1, 64'h0);

    // Zero register, including while a write to x0 is pending
    @(negedge clk);
    register3 = 5'd0;
    datain    = 64'hFFFFFFFFFFFFFFFF;
    regwrite  = 1'b1;
    register1 = 5'd0;
    register2 = 5'd0;
    #1;
    check("x0_pending_write", dataout1, 64'h0);
    @(posedge clk);
    #1;
    regwrite = 1'b0;
    #1;
    check("x0_rd1", dataout1, 64'h0);
    check("x0_rd2", dataout2, 64'h0);

    // Dual read, same cycle
    write_reg(5'd7, 64'hA5);
    write_reg(5'd8, 64'h5A);
    register1 = 5'd7;
    register2 = 5'd8;
    #1;
    check("dual_rd1_x7", dataout1, 64'hA5);
    check("dual_rd2_x8", dataout2, 64'h5A);
    register1 = 5'd8;
    #1;
    check("same_idx_rd1", dataout1, 64'h5A);
    check("same_idx_rd2", dataout2, 64'h5A);

    // Read-during-write
    write_reg(5'd9, 64'h1111);
    @(negedge clk);
    register1 = 5'd9;
    register3 = 5'd9;
    datain    = 64'h2222;
    regwrite  = 1'b1;
    #1;
`ifdef REGISTER_BANK_WRITE_BYPASS_EN
    check("rdw_before_edge", dataout1, 64'h2222);
`else
    check("rdw_before_edge", dataout1, 64'h1111);
`endif
    @(posedge clk);
    #1;
    regwrite = 1'b0;
    #1;
    check("rdw_after_edge", dataout1, 64'h2222);

    // Earlier entries untouched by later writes
    register1 = 5'd2;
    register2 = 5'd7;
    #1;
    check("hold_x2", dataout1, 64'h123456789ABCDEF0);
    check("hold_x7", dataout2, 64'hA5);

    // Reset mid-run clears without a clock edge
    write_reg(5'd5, 64'hCAFEF00DCAFEF00D);
    write_reg(5'd31, 64'h0123456789ABCDEF);
    register1 = 5'd5;
    register2 = 5'd31;
    #1;
    check("pre_reset_x5", dataout1, 64'hCAFEF00DCAFEF00D);
    check("pre_reset_x31", dataout2, 64'h0123456789ABCDEF);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_rd1", dataout1, 64'h0);
    check("async_reset_rd2", dataout2, 64'h0);

    // Writes ignored (and not forwarded) during reset
    register3 = 5'd5;
    datain    = 64'h7777777777777777;
    regwrite  = 1'b1;
    #1;
    check("reset_no_forward", dataout1, 64'h0);
    @(posedge clk);
    #1;
    check("reset_write_ignored", dataout1, 64'h0);
    @(negedge clk);
    regwrite = 1'b0;
    rst_n    = 1'b1;
    register2 = 5'd2;
    #1;
    check("post_reset_x5", dataout1, 64'h0);
    check("post_reset_x2", dataout2, 64'h0);

    // Bank writable again after reset
    write_reg(5'd31, 64'hFEDCBA9876543210);
    register2 = 5'd31;
    #1;
    check("post_reset_write_x31", dataout2, 64'hFEDCBA9876543210);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
